// File: rtl/nearest_hit_reducer.sv
// Reduces NUM_BLOCKS per-block intersection beats for one pixel to the nearest hit,
// then queues the winner in a small output FIFO with ready/valid handshake.
module nearest_hit_reducer #(
  parameter int NUM_BLOCKS     = 16,
  parameter int INDEX_WIDTH    = 4,
  parameter int OUT_DEPTH      = 2,
  parameter bit PRIORITY_MODE  = 1'b0,
  parameter int PRIORITY_INDEX = 13
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_in,
  input  logic [10:0]            x_in,
  input  logic [9:0]             y_in,
  input  logic [INDEX_WIDTH-1:0] block_index_in,
  input  logic                   intersect_in,
  input  logic [31:0]            t_in,
  input  logic [31:0]            ray_x_in,
  input  logic [31:0]            ray_y_in,
  input  logic [31:0]            ray_z_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [10:0]            x_out,
  output logic [9:0]             y_out,
  output logic                   hit_out,
  output logic [INDEX_WIDTH-1:0] block_index_out,
  output logic [31:0]            t_out,
  output logic [31:0]            ray_x_out,
  output logic [31:0]            ray_y_out,
  output logic [31:0]            ray_z_out,
  output logic                   overflow_out,
  output logic                   sync_err_out
);

  localparam int CW = $clog2(NUM_BLOCKS);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int NW = $clog2(OUT_DEPTH + 1);
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic [10:0]            x;
    logic [9:0]             y;
    logic                   hit;
    logic [INDEX_WIDTH-1:0] idx;
    logic [31:0]            t;
    logic [31:0]            rx;
    logic [31:0]            ry;
    logic [31:0]            rz;
  } result_t;

  logic [CW-1:0] cnt_reg;
  result_t       acc_reg, acc_next;
  logic          acc_prio_reg, acc_prio_next;
  logic          overflow_reg, sync_err_reg;

  logic    mismatch, first, last, is_nan, cand, cand_prio, better, take;
  result_t beat_rec, result;

  always_comb begin
    mismatch  = valid_in && (cnt_reg != '0) && ((x_in != acc_reg.x) || (y_in != acc_reg.y));
    first     = (cnt_reg == '0) || mismatch;
    last      = valid_in && !mismatch && (cnt_reg == CW'(NUM_BLOCKS - 1));
    is_nan    = (t_in[30:23] == 8'hFF) && (t_in[22:0] != '0);
    cand      = intersect_in && !t_in[31] && !is_nan;
    cand_prio = (PRIORITY_MODE != 1'b0) && (block_index_in == INDEX_WIDTH'(PRIORITY_INDEX));
    // A priority hit beats any ordinary hit; within the same class the smaller t wins, ties keep the earlier beat.
    better    = !acc_reg.hit || (cand_prio && !acc_prio_reg) ||
                ((cand_prio == acc_prio_reg) && (t_in[30:0] < acc_reg.t[30:0]));
    take      = cand && (first || better);

    beat_rec     = '0;
    beat_rec.x   = x_in;
    beat_rec.y   = y_in;
    beat_rec.hit = cand;
    beat_rec.idx = block_index_in;
    beat_rec.t   = t_in;
    beat_rec.rx  = ray_x_in;
    beat_rec.ry  = ray_y_in;
    beat_rec.rz  = ray_z_in;

    acc_next      = acc_reg;
    acc_prio_next = acc_prio_reg;
    if (first || take) begin
      acc_next      = beat_rec;
      acc_prio_next = cand && cand_prio;
    end

    // Without any candidate the ray still comes from the final beat of the group.
    result     = acc_next;
    result.idx = acc_next.hit ? acc_next.idx : '0;
    result.t   = acc_next.hit ? acc_next.t  : POS_INF;
    result.rx  = acc_next.hit ? acc_next.rx : ray_x_in;
    result.ry  = acc_next.hit ? acc_next.ry : ray_y_in;
    result.rz  = acc_next.hit ? acc_next.rz : ray_z_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_reg      <= '0;
      acc_reg      <= '0;
      acc_prio_reg <= 1'b0;
      sync_err_reg <= 1'b0;
    end else if (valid_in) begin
      acc_reg      <= acc_next;
      acc_prio_reg <= acc_prio_next;
      if (last)
        cnt_reg <= '0;
      else if (mismatch)
        cnt_reg <= CW'(1);
      else
        cnt_reg <= cnt_reg + CW'(1);
      if (mismatch)
        sync_err_reg <= 1'b1;
    end
  end

  // Output FIFO
  result_t        mem [OUT_DEPTH];
  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [NW-1:0]  count_reg;
  logic           full, pop, wr_en;
  result_t        head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_reg == NW'(OUT_DEPTH));
  assign pop   = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = last && (!full || pop);

  always_ff @(posedge clk_in) begin
    if (wr_en)
      mem[wr_ptr_reg] <= result;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (wr_en && !pop)
        count_reg <= count_reg + NW'(1);
      else if (pop && !wr_en)
        count_reg <= count_reg - NW'(1);
      if (last && !wr_en)
        overflow_reg <= 1'b1;
    end
  end

  assign out_valid       = (count_reg != '0);
  assign head            = out_valid ? mem[rd_ptr_reg] : '0;
  assign x_out           = head.x;
  assign y_out           = head.y;
  assign hit_out         = head.hit;
  assign block_index_out = head.idx;
  assign t_out           = head.t;
  assign ray_x_out       = head.rx;
  assign ray_y_out       = head.ry;
  assign ray_z_out       = head.rz;
  assign overflow_out    = overflow_reg;
  assign sync_err_out    = sync_err_reg;

endmodule

// File: tb/tb_nearest_hit_reducer.sv
// Directed bench for nearest_hit_reducer with NUM_BLOCKS=4, OUT_DEPTH=2; a second
// instance with PRIORITY_MODE=0 shares the inputs for the priority comparison.
module tb_nearest_hit_reducer;

  logic        clk_in = 1'b0;
  logic        rst_in, valid_in, intersect_in, out_ready;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic [3:0]  block_index_in;
  logic [31:0] t_in, ray_x_in, ray_y_in, ray_z_in;

  logic        out_valid, hit_out, overflow_out, sync_err_out;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [3:0]  block_index_out;
  logic [31:0] t_out, ray_x_out, ray_y_out, ray_z_out;

  logic        ready0 = 1'b1;
  logic        p0_valid, p0_hit, p0_overflow, p0_sync_err;
  logic [10:0] p0_x;
  logic [9:0]  p0_y;
  logic [3:0]  p0_idx;
  logic [31:0] p0_t, p0_rx, p0_ry, p0_rz;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_in = ~clk_in;

  nearest_hit_reducer #(
    .NUM_BLOCKS(4), .INDEX_WIDTH(4), .OUT_DEPTH(2), .PRIORITY_MODE(1'b1), .PRIORITY_INDEX(13)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .x_in(x_in), .y_in(y_in),
    .block_index_in(block_index_in), .intersect_in(intersect_in), .t_in(t_in),
    .ray_x_in(ray_x_in), .ray_y_in(ray_y_in), .ray_z_in(ray_z_in), .out_ready(out_ready),
    .out_valid(out_valid), .x_out(x_out), .y_out(y_out), .hit_out(hit_out),
    .block_index_out(block_index_out), .t_out(t_out), .ray_x_out(ray_x_out),
    .ray_y_out(ray_y_out), .ray_z_out(ray_z_out), .overflow_out(overflow_out),
    .sync_err_out(sync_err_out)
  );

  nearest_hit_reducer #(
    .NUM_BLOCKS(4), .INDEX_WIDTH(4), .OUT_DEPTH(2), .PRIORITY_MODE(1'b0), .PRIORITY_INDEX(13)
  ) dut0 (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .x_in(x_in), .y_in(y_in),
    .block_index_in(block_index_in), .intersect_in(intersect_in), .t_in(t_in),
    .ray_x_in(ray_x_in), .ray_y_in(ray_y_in), .ray_z_in(ray_z_in), .out_ready(ready0),
    .out_valid(p0_valid), .x_out(p0_x), .y_out(p0_y), .hit_out(p0_hit),
    .block_index_out(p0_idx), .t_out(p0_t), .ray_x_out(p0_rx),
    .ray_y_out(p0_ry), .ray_z_out(p0_rz), .overflow_out(p0_overflow),
    .sync_err_out(p0_sync_err)
  );

  // One beat; the ray encodes the block index so the winner's ray is recognisable.
  task automatic beat(input logic [10:0] x, input logic [9:0] y, input logic [3:0] idx,
                      input logic hit, input logic [31:0] t);
    valid_in       = 1'b1;
    x_in           = x;
    y_in           = y;
    block_index_in = idx;
    intersect_in   = hit;
    t_in           = t;
    ray_x_in       = 32'h1000_0000 + 32'(idx);
    ray_y_in       = 32'h2000_0000 + 32'(idx);
    ray_z_in       = 32'h3000_0000 + 32'(idx);
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic run_group(input logic [10:0] x, input logic [9:0] y, input logic [15:0] idxs,
                           input logic [3:0] hits, input logic [127:0] ts, input logic [3:0] ready_mask);
    for (int i = 0; i < 4; i++) begin
      out_ready = ready_mask[i];
      beat(x, y, idxs[4*i +: 4], hits[i], ts[32*i +: 32]);
    end
    out_ready = 1'b0;
  endtask

  task automatic pop_one();
    $display("pop x=%0d y=%0d hit=%0d idx=%0d t=%h", x_out, y_out, hit_out, block_index_out, t_out);
    out_ready = 1'b1;
    @(posedge clk_in);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; valid_in = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;
    block_index_in = '0; intersect_in = 1'b0; t_in = '0;
    ray_x_in = '0; ray_y_in = '0; ray_z_in = '0;
    #2;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0h want 0", out_valid); else n_pass++;
    n_checks++; if (t_out !== 32'h0) $display("FAIL reset_t: got %h want 0", t_out); else n_pass++;
    n_checks++; if ({overflow_out, sync_err_out} !== 2'b00) $display("FAIL reset_sticky: got %b want 00", {overflow_out, sync_err_out}); else n_pass++;
    repeat (2) @(posedge clk_in);
    #5 rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    $display("reset released");
  endtask

  task automatic test_basic();
    beat(11'd5, 10'd7, 4'd0, 1'b1, 32'h4040_0000);
    beat(11'd5, 10'd7, 4'd1, 1'b1, 32'h3F80_0000);
    beat(11'd5, 10'd7, 4'd2, 1'b1, 32'h3F80_0000);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %0h want 0", out_valid); else n_pass++;
    beat(11'd5, 10'd7, 4'd3, 1'b1, 32'h4000_0000);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %0h want 1", out_valid); else n_pass++;
    n_checks++; if (block_index_out !== 4'd1) $display("FAIL basic_idx: got %0d want 1", block_index_out); else n_pass++;
    n_checks++; if (t_out !== 32'h3F80_0000) $display("FAIL basic_t: got %h want 3f800000", t_out); else n_pass++;
    n_checks++; if (hit_out !== 1'b1) $display("FAIL basic_hit: got %0h want 1", hit_out); else n_pass++;
    n_checks++; if ({x_out, y_out} !== {11'd5, 10'd7}) $display("FAIL basic_xy: got %0d,%0d want 5,7", x_out, y_out); else n_pass++;
    n_checks++; if ({ray_x_out, ray_y_out, ray_z_out} !== {32'h1000_0001, 32'h2000_0001, 32'h3000_0001})
      $display("FAIL basic_ray: got %h %h %h want 10000001 20000001 30000001", ray_x_out, ray_y_out, ray_z_out); else n_pass++;
    pop_one();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_popped: got %0h want 0", out_valid); else n_pass++;
  endtask

  task automatic test_no_hit();
    run_group(11'd6, 10'd1, 16'h3210, 4'b0000, {4{32'h3F80_0000}}, 4'b0000);
    n_checks++; if ({hit_out, block_index_out, t_out} !== {1'b0, 4'd0, 32'h7F80_0000})
      $display("FAIL nohit_miss: got hit=%0h idx=%0d t=%h want 0 0 7f800000", hit_out, block_index_out, t_out); else n_pass++;
    n_checks++; if (ray_x_out !== 32'h1000_0003) $display("FAIL nohit_ray: got %h want 10000003", ray_x_out); else n_pass++;
    pop_one();
    run_group(11'd6, 10'd2, 16'h3210, 4'b1111, {4{32'hBF80_0000}}, 4'b0000);
    n_checks++; if ({out_valid, hit_out, block_index_out, t_out} !== {1'b1, 1'b0, 4'd0, 32'h7F80_0000})
      $display("FAIL nohit_neg: got v=%0h hit=%0h idx=%0d t=%h want 1 0 0 7f800000", out_valid, hit_out, block_index_out, t_out); else n_pass++;
    pop_one();
    run_group(11'd6, 10'd3, 16'h3210, 4'b0001, {{3{32'h3F80_0000}}, 32'h7FC0_0000}, 4'b0000);
    n_checks++; if ({out_valid, hit_out, t_out} !== {1'b1, 1'b0, 32'h7F80_0000})
      $display("FAIL nohit_nan: got v=%0h hit=%0h t=%h want 1 0 7f800000", out_valid, hit_out, t_out); else n_pass++;
    pop_one();
  endtask

  task automatic test_priority();
    run_group(11'd8, 10'd9, {4'd3, 4'd13, 4'd2, 4'd0}, 4'b0110,
              {32'h0, 32'h4110_0000, 32'h3F80_0000, 32'h0}, 4'b0000);
    n_checks++; if ({out_valid, block_index_out, t_out} !== {1'b1, 4'd13, 32'h4110_0000})
      $display("FAIL prio_on: got v=%0h idx=%0d t=%h want 1 13 41100000", out_valid, block_index_out, t_out); else n_pass++;
    n_checks++; if (ray_x_out !== 32'h1000_000D) $display("FAIL prio_on_ray: got %h want 1000000d", ray_x_out); else n_pass++;
    n_checks++; if ({p0_valid, p0_hit, p0_idx, p0_t} !== {1'b1, 1'b1, 4'd2, 32'h3F80_0000})
      $display("FAIL prio_off: got v=%0h hit=%0h idx=%0d t=%h want 1 1 2 3f800000", p0_valid, p0_hit, p0_idx, p0_t); else n_pass++;
    n_checks++; if ({p0_x, p0_y} !== {11'd8, 10'd9}) $display("FAIL prio_off_xy: got %0d,%0d want 8,9", p0_x, p0_y); else n_pass++;
    n_checks++; if ({p0_rx, p0_ry, p0_rz} !== {32'h1000_0002, 32'h2000_0002, 32'h3000_0002})
      $display("FAIL prio_off_ray: got %h %h %h want 10000002 20000002 30000002", p0_rx, p0_ry, p0_rz); else n_pass++;
    n_checks++; if ({p0_overflow, p0_sync_err} !== 2'b00) $display("FAIL prio_off_sticky: got %b want 00", {p0_overflow, p0_sync_err}); else n_pass++;
    pop_one();
  endtask

  task automatic test_back_to_back();
    run_group(11'd30, 10'd4, 16'h3210, 4'b1111,
              {32'h4080_0000, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000}, 4'b0000);
    n_checks++; if ({out_valid, x_out, block_index_out} !== {1'b1, 11'd30, 4'd1})
      $display("FAIL b2b_first: got v=%0h x=%0d idx=%0d want 1 30 1", out_valid, x_out, block_index_out); else n_pass++;
    $display("pop x=%0d idx=%0d (during next group)", x_out, block_index_out);
    run_group(11'd31, 10'd4, 16'h3210, 4'b1111,
              {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000}, 4'b0001);
    n_checks++; if ({out_valid, x_out, block_index_out, t_out} !== {1'b1, 11'd31, 4'd3, 32'h3F80_0000})
      $display("FAIL b2b_second: got v=%0h x=%0d idx=%0d t=%h want 1 31 3 3f800000", out_valid, x_out, block_index_out, t_out); else n_pass++;
    pop_one();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %0h want 0", out_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    run_group(11'd10, 10'd0, 16'h3210, 4'b1111, {4{32'h3F80_0000}}, 4'b0000);
    n_checks++; if ({out_valid, x_out} !== {1'b1, 11'd10}) $display("FAIL ovf_g1: got v=%0h x=%0d want 1 10", out_valid, x_out); else n_pass++;
    run_group(11'd11, 10'd0, 16'h3210, 4'b1111, {4{32'h3F80_0000}}, 4'b0000);
    n_checks++; if (overflow_out !== 1'b0) $display("FAIL ovf_full_no_drop: got %0h want 0", overflow_out); else n_pass++;
    run_group(11'd12, 10'd0, 16'h3210, 4'b1111, {4{32'h3F80_0000}}, 4'b0000);
    n_checks++; if (overflow_out !== 1'b1) $display("FAIL ovf_set: got %0h want 1", overflow_out); else n_pass++;
    n_checks++; if ({out_valid, x_out} !== {1'b1, 11'd10}) $display("FAIL ovf_head_stable: got v=%0h x=%0d want 1 10", out_valid, x_out); else n_pass++;
    run_group(11'd13, 10'd0, 16'h3210, 4'b1111, {4{32'h3F80_0000}}, 4'b1000);
    n_checks++; if ({out_valid, x_out} !== {1'b1, 11'd11}) $display("FAIL ovf_pushpop_head: got v=%0h x=%0d want 1 11", out_valid, x_out); else n_pass++;
    pop_one();
    n_checks++; if ({out_valid, x_out} !== {1'b1, 11'd13}) $display("FAIL ovf_pushpop_kept: got v=%0h x=%0d want 1 13", out_valid, x_out); else n_pass++;
    pop_one();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL ovf_drained: got %0h want 0", out_valid); else n_pass++;
  endtask

  task automatic test_sync_err();
    n_checks++; if (sync_err_out !== 1'b0) $display("FAIL sync_before: got %0h want 0", sync_err_out); else n_pass++;
    beat(11'd20, 10'd3, 4'd0, 1'b1, 32'h3F00_0000);
    beat(11'd20, 10'd3, 4'd1, 1'b1, 32'h4040_0000);
    beat(11'd21, 10'd3, 4'd2, 1'b1, 32'h4000_0000);
    n_checks++; if (sync_err_out !== 1'b1) $display("FAIL sync_set: got %0h want 1", sync_err_out); else n_pass++;
    beat(11'd21, 10'd3, 4'd3, 1'b1, 32'h4040_0000);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL sync_no_old_group: got %0h want 0", out_valid); else n_pass++;
    beat(11'd21, 10'd3, 4'd1, 1'b1, 32'h3F80_0000);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL sync_early: got %0h want 0", out_valid); else n_pass++;
    beat(11'd21, 10'd3, 4'd0, 1'b1, 32'h4080_0000);
    n_checks++; if ({out_valid, x_out, block_index_out, t_out} !== {1'b1, 11'd21, 4'd1, 32'h3F80_0000})
      $display("FAIL sync_restart: got v=%0h x=%0d idx=%0d t=%h want 1 21 1 3f800000", out_valid, x_out, block_index_out, t_out); else n_pass++;
    pop_one();
  endtask

  task automatic test_reset_mid();
    run_group(11'd40, 10'd5, 16'h3210, 4'b1111, {4{32'h3F80_0000}}, 4'b0000);
    n_checks++; if ({out_valid, sync_err_out} !== 2'b11) $display("FAIL rstmid_pre: got %b want 11", {out_valid, sync_err_out}); else n_pass++;
    beat(11'd41, 10'd5, 4'd0, 1'b1, 32'h3F00_0000);
    beat(11'd41, 10'd5, 4'd1, 1'b1, 32'h3F00_0000);
    valid_in = 1'b1; block_index_in = 4'd2;
    rst_in = 1'b0;
    #1;
    n_checks++; if ({out_valid, hit_out, overflow_out, sync_err_out} !== 4'b0000)
      $display("FAIL rstmid_flags: got %b want 0000", {out_valid, hit_out, overflow_out, sync_err_out}); else n_pass++;
    n_checks++; if ({x_out, y_out, block_index_out, t_out, ray_x_out, ray_y_out, ray_z_out} !== '0)
      $display("FAIL rstmid_data: got x=%0d y=%0d idx=%0d t=%h rx=%h want all 0", x_out, y_out, block_index_out, t_out, ray_x_out); else n_pass++;
    valid_in = 1'b0;
    #3 rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    beat(11'd42, 10'd6, 4'd0, 1'b1, 32'h4000_0000);
    beat(11'd42, 10'd6, 4'd1, 1'b1, 32'h4040_0000);
    beat(11'd42, 10'd6, 4'd2, 1'b0, 32'h3F80_0000);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_early: got %0h want 0", out_valid); else n_pass++;
    beat(11'd42, 10'd6, 4'd3, 1'b1, 32'h4080_0000);
    n_checks++; if ({out_valid, x_out, block_index_out, t_out} !== {1'b1, 11'd42, 4'd0, 32'h4000_0000})
      $display("FAIL rstmid_result: got v=%0h x=%0d idx=%0d t=%h want 1 42 0 40000000", out_valid, x_out, block_index_out, t_out); else n_pass++;
    pop_one();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_single: got %0h want 0", out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_hit();
    test_priority();
    test_back_to_back();
    test_overflow();
    test_sync_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nearest_hit_reducer.md
NEAREST_HIT_REDUCER -- requirements
Module: nearest_hit_reducer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_BLOCKS, 16, per-block results per pixel group (>=2).
- INDEX_WIDTH, 4, block index width.
- OUT_DEPTH, 2, output FIFO entries (>=1).
- PRIORITY_MODE, 0, 1 = a hit from PRIORITY_INDEX wins over any t.
- PRIORITY_INDEX, 13, priority (saber) block index.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. The block has one clock; reset is asynchronous and active-low.
- clk_in, in, 1, clock.
- rst_in, in, 1, asynchronous active-low reset.
- valid_in, in, 1, per-block result beat valid; no backpressure.
- x_in, in, 11, pixel x.
- y_in, in, 10, pixel y.
- block_index_in, in, INDEX_WIDTH, block index.
- intersect_in, in, 1, ray hits block (already visibility-gated).
- t_in, in, 32, IEEE-754 single hit distance.
- ray_x_in, ray_y_in, ray_z_in, in, 32 each, ray direction floats.
- out_ready, in, 1, downstream accepts.
- out_valid, out, 1, result available.
- x_out, out, 11, pixel x.
- y_out, out, 10, pixel y.
- hit_out, out, 1, any valid hit.
- block_index_out, out, INDEX_WIDTH, winning block index.
- t_out, out, 32, winning t.
- ray_x_out, ray_y_out, ray_z_out, out, 32 each, ray of the winning beat.
- overflow_out, out, 1, sticky: a result was dropped.
- sync_err_out, out, 1, sticky: group x/y mismatch.

Function
REQ-003 A group SHALL be NUM_BLOCKS consecutive valid_in beats; a beat counter runs 0..NUM_BLOCKS-1 and wraps to 0 after the last beat; idle cycles (valid_in=0) SHALL NOT advance it.
REQ-004 On beat 0 the block SHALL capture x_in/y_in and initialise the accumulator with that beat's candidacy.
REQ-005 A beat SHALL be a candidate iff intersect_in=1 and t_in[31]=0; NaN (exp=0xFF, mantissa!=0) SHALL NOT be a candidate.
REQ-006 Candidates SHALL be compared as unsigned t_in[30:0]; a strictly smaller t replaces the best; on a tie the earlier beat is kept.
REQ-007 With PRIORITY_MODE=1, a candidate with block_index_in==PRIORITY_INDEX SHALL replace any non-priority best regardless of t; between two priority candidates, REQ-006 applies.
REQ-008 If a beat k>0 has x_in/y_in different from the captured values, sync_err_out SHALL set; that beat SHALL restart the group as beat 0; the partial group SHALL be discarded.
REQ-009 The cycle after beat NUM_BLOCKS-1 the result SHALL be pushed into the OUT_DEPTH FIFO, and out_valid SHALL be high in that cycle if the FIFO was empty.
REQ-010 The pushed result SHALL carry the captured x/y and the winner's index, t and ray. With no candidate: hit_out=0, block_index_out=0, t_out=0x7F800000, and the ray is taken from the last beat.
REQ-011 A pop SHALL occur on out_valid && out_ready. Outputs SHALL be stable while out_valid=1 and out_ready=0.
REQ-012 If a push and a pop occur in the same cycle, both SHALL complete even when the FIFO is full.
REQ-013 A push to a full FIFO without a pop SHALL drop the new result and set overflow_out.
REQ-014 Back-to-back groups SHALL be accepted with zero idle cycles, giving a throughput of 1 beat per cycle.

Reset
REQ-015 While rst_in=0, asynchronously: the counter SHALL be 0, the accumulator and FIFO SHALL be empty, and all outputs SHALL be 0.
REQ-016 An assertion of rst_in mid-group SHALL discard the partial group. After release, the next valid beat SHALL be beat 0.

Verification
REQ-017 With NUM_BLOCKS=4, the bench SHALL drive pixel (5,7) with t={3.0,1.0,1.0,2.0}, all hit, indices 0..3. Required response: one cycle after beat 3, out_valid=1, index=1, t=0x3F800000, hit=1.
REQ-018 The bench SHALL drive all beats with intersect_in=0, or with t=-1.0. Required response: hit_out=0, t_out=0x7F800000, index=0.
REQ-019 With PRIORITY_MODE=1, the bench SHALL drive index 13 with t=9.0 and index 2 with t=1.0. Required response: index 13, t=0x41100000. With PRIORITY_MODE=0 the required response is index 2.
REQ-020 The bench SHALL hold out_ready=0 across 3 groups with OUT_DEPTH=2. Required response: the first two results are retained in order, the third is dropped, and overflow_out=1. When the bench then drives a simultaneous push and pop with the FIFO full, no drop SHALL occur.
REQ-021 The bench SHALL change x_in at beat 2. Required response: sync_err_out=1, and the next group is output with the new x after NUM_BLOCKS beats counted from the mismatch beat.
REQ-022 The bench SHALL assert rst_in=0 at beat 2. Required response: all outputs are 0 immediately. After release, a full group yields exactly one result.
